// File: rtl/slot_ctrl_pkg.sv
// Shared types for the dual-hash slot-allocation controller.
//   op_t     : request opcode (insert / delete)
//   status_t : response status returned to the key/value store stage
//   state_t  : controller FSM states
package slot_ctrl_pkg;

  typedef enum logic {
    OP_INSERT = 1'b0,
    OP_DELETE = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_FULL      = 2'd1,
    ST_NOT_FOUND = 2'd2
  } status_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DECIDE = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/dual_hash_slot_ctrl_if.sv
// Request/response bus of the slot controller.
//   Request : in_valid, in_ready, in_op, in_key, in_way
//   Response: out_valid, out_ready, out_adr, out_way, out_status
//   master  : requester / response consumer side
//   slave   : the controller
interface dual_hash_slot_ctrl_if #(
  parameter int unsigned SIZE  = 10,
  parameter int unsigned KEY_W = 32
);

  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic [KEY_W-1:0] in_key;
  logic             in_way;

  logic             out_valid;
  logic             out_ready;
  logic [SIZE-1:0]  out_adr;
  logic             out_way;
  logic [1:0]       out_status;

  modport master (
    output in_valid, in_op, in_key, in_way, out_ready,
    input  in_ready, out_valid, out_adr, out_way, out_status
  );

  modport slave (
    input  in_valid, in_op, in_key, in_way, out_ready,
    output in_ready, out_valid, out_adr, out_way, out_status
  );

endinterface

// File: rtl/dual_hash.sv
// Combinational dual hash of a key into two SIZE-bit slot addresses.
//   key : KEY_W-bit key
//   h0  : XOR of SIZE-bit key chunks, LSB chunk first, last chunk zero-padded
//   h1  : bitreverse(h0) ^ H1_SEED
module dual_hash #(
  parameter int unsigned     SIZE    = 10,
  parameter int unsigned     KEY_W   = 32,
  parameter logic [SIZE-1:0] H1_SEED = {SIZE{1'b1}}
) (
  input  logic [KEY_W-1:0] key,
  output logic [SIZE-1:0]  h0,
  output logic [SIZE-1:0]  h1
);

  localparam int unsigned NChunk = (KEY_W + SIZE - 1) / SIZE;

  logic [NChunk*SIZE-1:0] key_pad;
  logic [SIZE-1:0]        h0_rev;

  always_comb begin
    key_pad = '0;
    key_pad[KEY_W-1:0] = key;
    h0 = '0;
    for (int unsigned i = 0; i < NChunk; i++) begin
      h0 = h0 ^ key_pad[i*SIZE +: SIZE];
    end
    h0_rev = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      h0_rev[i] = h0[SIZE-1-i];
    end
    h1 = h0_rev ^ H1_SEED;
  end

endmodule

// File: rtl/dual_hash_slot_ctrl.sv
// Dual-hash slot-allocation controller sitting in front of the occupancy flag
// register. Each request is hashed to two candidate slots whose flags are read
// through the flag register; inserts take the first free candidate, deletes
// clear the way selected by the requester. One operation per four cycles.
//
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   bus (slave)             : request / response handshake bus
//   read_adr_0/1            : flag register read addresses (h0 / h1)
//   flag_in_0/1             : flag register read data, one cycle after address
//   write_adr/en/is_valid   : single-cycle flag write (1=set, 0=clear)
//   occupancy               : live slot count
//
// Optional: define SLOT_OCCUPANCY_EN to build the saturating occupancy counter;
// otherwise occupancy is tied to 0.
module dual_hash_slot_ctrl
  import slot_ctrl_pkg::*;
#(
  parameter int unsigned     SIZE    = 10,
  parameter int unsigned     KEY_W   = 32,
  parameter logic [SIZE-1:0] H1_SEED = {SIZE{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset,
  dual_hash_slot_ctrl_if.slave  bus,
  output logic [SIZE-1:0]       read_adr_0,
  output logic [SIZE-1:0]       read_adr_1,
  input  logic                  flag_in_0,
  input  logic                  flag_in_1,
  output logic [SIZE-1:0]       write_adr,
  output logic                  write_en,
  output logic                  write_is_valid,
  output logic [SIZE:0]         occupancy
);

  state_t           state_q;
  op_t              op_q;
  logic [KEY_W-1:0] key_q;
  logic             way_q;
  logic [SIZE-1:0]  rd_adr0_q, rd_adr1_q;
  logic [SIZE-1:0]  write_adr_q;
  logic             write_en_q, write_val_q;
  logic             out_valid_q, out_way_q;
  logic [SIZE-1:0]  out_adr_q;
  status_t          out_status_q;

  logic [SIZE-1:0]  h0, h1;

  dual_hash #(
    .SIZE    (SIZE),
    .KEY_W   (KEY_W),
    .H1_SEED (H1_SEED)
  ) u_hash (
    .key (key_q),
    .h0  (h0),
    .h1  (h1)
  );

  // Addresses are live from the hash during READ and then held for the rest
  // of the operation, so the flag register sees them one cycle before DECIDE.
  assign read_adr_0 = (state_q == READ) ? h0 : rd_adr0_q;
  assign read_adr_1 = (state_q == READ) ? h1 : rd_adr1_q;

  assign bus.in_ready   = (state_q == IDLE) && !reset;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_adr    = out_adr_q;
  assign bus.out_way    = out_way_q;
  assign bus.out_status = out_status_q;

  assign write_adr      = write_adr_q;
  assign write_en       = write_en_q;
  assign write_is_valid = write_val_q;

  // Write decision, evaluated against the held addresses in DECIDE.
  logic            dec_we, dec_val, dec_way, dec_sel;
  logic [SIZE-1:0] dec_adr;
  status_t         dec_status;

  always_comb begin
    dec_we     = 1'b0;
    dec_val    = 1'b0;
    dec_way    = 1'b0;
    dec_adr    = rd_adr0_q;
    dec_status = ST_OK;
    dec_sel    = way_q ? flag_in_1 : flag_in_0;
    if (op_q == OP_INSERT) begin
      if (!flag_in_0) begin
        dec_we  = 1'b1;
        dec_val = 1'b1;
      end else if (!flag_in_1) begin
        dec_we  = 1'b1;
        dec_val = 1'b1;
        dec_way = 1'b1;
        dec_adr = rd_adr1_q;
      end else begin
        dec_status = ST_FULL;
      end
    end else begin
      dec_way = way_q;
      if (dec_sel) begin
        dec_we  = 1'b1;
        dec_adr = way_q ? rd_adr1_q : rd_adr0_q;
      end else begin
        dec_status = ST_NOT_FOUND;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= OP_INSERT;
      key_q        <= '0;
      way_q        <= 1'b0;
      rd_adr0_q    <= '0;
      rd_adr1_q    <= '0;
      write_adr_q  <= '0;
      write_en_q   <= 1'b0;
      write_val_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_adr_q    <= '0;
      out_way_q    <= 1'b0;
      out_status_q <= ST_OK;
    end else begin
      write_en_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_q    <= op_t'(bus.in_op);
            key_q   <= bus.in_key;
            way_q   <= bus.in_way;
            state_q <= READ;
          end
        end
        READ: begin
          rd_adr0_q <= h0;
          rd_adr1_q <= h1;
          state_q   <= DECIDE;
        end
        DECIDE: begin
          if (dec_we) begin
            write_adr_q <= dec_adr;
            write_val_q <= dec_val;
            write_en_q  <= 1'b1;
          end
          out_valid_q  <= 1'b1;
          out_adr_q    <= dec_adr;
          out_way_q    <= dec_way;
          out_status_q <= dec_status;
          state_q      <= RESP;
        end
        RESP: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SLOT_OCCUPANCY_EN
  localparam logic [SIZE:0] OccMax = {1'b1, {SIZE{1'b0}}};

  logic [SIZE:0] occ_q;

  // Every committed write is an OK result, so the write strobe alone counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else if (state_q == DECIDE && dec_we) begin
      if (dec_val && occ_q != OccMax) begin
        occ_q <= occ_q + 1'b1;
      end else if (!dec_val && occ_q != '0) begin
        occ_q <= occ_q - 1'b1;
      end
    end
  end

  assign occupancy = occ_q;
`else
  assign occupancy = '0;
`endif

endmodule

// File: tb/tb_dual_hash_slot_ctrl.sv
// Directed self-checking bench for dual_hash_slot_ctrl (SIZE=4, KEY_W=8,
// H1_SEED=4'h5) paired with a behavioural 16-entry flag register.
module tb_dual_hash_slot_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] read_adr_0, read_adr_1;
  logic       flag_in_0, flag_in_1;
  logic [3:0] write_adr;
  logic       write_en, write_is_valid;
  logic [4:0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  dual_hash_slot_ctrl_if #(.SIZE(4), .KEY_W(8)) ifc ();

  dual_hash_slot_ctrl #(
    .SIZE    (4),
    .KEY_W   (8),
    .H1_SEED (4'h5)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (ifc),
    .read_adr_0     (read_adr_0),
    .read_adr_1     (read_adr_1),
    .flag_in_0      (flag_in_0),
    .flag_in_1      (flag_in_1),
    .write_adr      (write_adr),
    .write_en       (write_en),
    .write_is_valid (write_is_valid),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  // Flag register: registered reads, write lands at the clock edge.
  logic [15:0] flags;
  always @(posedge clk) begin
    if (reset) begin
      flags <= '0;
    end else if (write_en) begin
      flags[write_adr] <= write_is_valid;
    end
    flag_in_0 <= flags[read_adr_0];
    flag_in_1 <= flags[read_adr_1];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request and return 1 time unit after its handshake edge.
  task automatic issue(input logic op, input logic [7:0] key, input logic way);
    int n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_op    = op;
    ifc.in_key   = key;
    ifc.in_way   = way;
    while (!ifc.in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("in_ready_wait", {31'd0, ifc.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic run_op(input logic op, input logic [7:0] key, input logic way,
                        input logic [3:0] e_h0, input logic [3:0] e_h1,
                        input logic e_we, input logic e_wval,
                        input logic [3:0] e_adr, input int e_way,
                        input logic [1:0] e_st, input int e_occ, input int hold);
    issue(op, key, way);
    // t+1: READ
    check_eq("read_adr_0", {28'd0, read_adr_0}, {28'd0, e_h0});
    check_eq("read_adr_1", {28'd0, read_adr_1}, {28'd0, e_h1});
    check_eq("in_ready_busy", {31'd0, ifc.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    // t+2: DECIDE
    check_eq("early_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    check_eq("early_write_en", {31'd0, write_en}, 32'd0);
    @(posedge clk);
    #1;
    // t+3: result
    check_eq("out_valid", {31'd0, ifc.out_valid}, 32'd1);
    check_eq("write_en", {31'd0, write_en}, {31'd0, e_we});
    if (e_we) begin
      check_eq("write_adr", {28'd0, write_adr}, {28'd0, e_adr});
      check_eq("write_is_valid", {31'd0, write_is_valid}, {31'd0, e_wval});
    end
    check_eq("out_adr", {28'd0, ifc.out_adr}, {28'd0, e_adr});
    if (e_way != 2) check_eq("out_way", {31'd0, ifc.out_way}, e_way);
    check_eq("out_status", {30'd0, ifc.out_status}, {30'd0, e_st});
`ifdef SLOT_OCCUPANCY_EN
    check_eq("occupancy", {27'd0, occupancy}, e_occ);
`else
    check_eq("occupancy", {27'd0, occupancy}, 32'd0);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold_out_valid", {31'd0, ifc.out_valid}, 32'd1);
      check_eq("hold_out_adr", {28'd0, ifc.out_adr}, {28'd0, e_adr});
      check_eq("hold_out_status", {30'd0, ifc.out_status}, {30'd0, e_st});
      check_eq("hold_in_ready", {31'd0, ifc.in_ready}, 32'd0);
      check_eq("hold_write_en", {31'd0, write_en}, 32'd0);
    end
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b0;
    check_eq("post_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    check_eq("post_write_en", {31'd0, write_en}, 32'd0);
    check_eq("post_in_ready", {31'd0, ifc.in_ready}, 32'd1);
  endtask

  initial begin
    reset         = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in_op     = 1'b0;
    ifc.in_key    = '0;
    ifc.in_way    = 1'b0;
    ifc.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", {31'd0, ifc.in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    check_eq("rst_write_en", {31'd0, write_en}, 32'd0);
    check_eq("rst_write_is_valid", {31'd0, write_is_valid}, 32'd0);
    check_eq("rst_read_adr_0", {28'd0, read_adr_0}, 32'd0);
    check_eq("rst_read_adr_1", {28'd0, read_adr_1}, 32'd0);
    check_eq("rst_out_status", {30'd0, ifc.out_status}, 32'd0);
    check_eq("rst_occupancy", {27'd0, occupancy}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("idle_in_ready", {31'd0, ifc.in_ready}, 32'd1);

    // op key way h0 h1 we wval adr way status occ hold
    run_op(1'b0, 8'h35, 1'b0, 4'h6, 4'h3, 1'b1, 1'b1, 4'h6, 0, 2'd0, 1, 0);
    run_op(1'b0, 8'h35, 1'b0, 4'h6, 4'h3, 1'b1, 1'b1, 4'h3, 1, 2'd0, 2, 0);
    run_op(1'b0, 8'h35, 1'b0, 4'h6, 4'h3, 1'b0, 1'b0, 4'h6, 0, 2'd1, 2, 0);
    run_op(1'b1, 8'h35, 1'b1, 4'h6, 4'h3, 1'b1, 1'b0, 4'h3, 1, 2'd0, 1, 0);
    run_op(1'b1, 8'h35, 1'b1, 4'h6, 4'h3, 1'b0, 1'b0, 4'h6, 2, 2'd2, 1, 0);
    run_op(1'b0, 8'hA7, 1'b0, 4'hD, 4'hE, 1'b1, 1'b1, 4'hD, 0, 2'd0, 2, 10);

    // Reset while the next op sits in DECIDE.
    issue(1'b0, 8'h12, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rstdec_write_en", {31'd0, write_en}, 32'd0);
    check_eq("rstdec_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    check_eq("rstdec_occupancy", {27'd0, occupancy}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rstdec_in_ready", {31'd0, ifc.in_ready}, 32'd1);

    run_op(1'b0, 8'h35, 1'b0, 4'h6, 4'h3, 1'b1, 1'b1, 4'h6, 0, 2'd0, 1, 0);
    run_op(1'b0, 8'h12, 1'b0, 4'h3, 4'h9, 1'b1, 1'b1, 4'h3, 0, 2'd0, 2, 0);
    run_op(1'b0, 8'hA7, 1'b0, 4'hD, 4'hE, 1'b1, 1'b1, 4'hD, 0, 2'd0, 3, 0);
    run_op(1'b1, 8'h12, 1'b0, 4'h3, 4'h9, 1'b1, 1'b0, 4'h3, 0, 2'd0, 2, 0);
    run_op(1'b0, 8'h35, 1'b0, 4'h6, 4'h3, 1'b1, 1'b1, 4'h3, 1, 2'd0, 3, 0);
    run_op(1'b0, 8'h35, 1'b0, 4'h6, 4'h3, 1'b0, 1'b0, 4'h6, 0, 2'd1, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
